// File: rtl/keypad_scanner_if.sv
// keypad_scanner_if: key event bus from the keypad scanner to the display block
//   key_code    [4:0]  bits [3:0] key index row*4+col, bit [4] auto-repeat flag
//   key_pressed        one-cycle strobe, key_code valid in the same cycle
//   key_held           high while the accepted key remains pressed
//   master: driven by the scanner; slave: consumed by the display block
interface keypad_scanner_if;
    logic [4:0] key_code;
    logic       key_pressed;
    logic       key_held;
    modport master(output key_code, key_pressed, key_held);
    modport slave(input key_code, key_pressed, key_held);
endinterface

// File: rtl/keypad_scanner.sv
// keypad_scanner: scans a 4x4 active-low keypad, debounces and encodes one key
//   clk       system clock
//   rst_n     asynchronous active-low reset
//   col_out   column drive, active-low, one-hot-low
//   row_in    row returns, active-low, asynchronous, pulled up
//   kp        key event bus (master): key_code, key_pressed, key_held
//   KEYPAD_AUTOREPEAT_EN enables auto-repeat strobes with key_code[4]=1
module keypad_scanner #(
    parameter int SCAN_DIV     = 1000,
    parameter int DEBOUNCE_CNT = 16,
    parameter int REPEAT_DELAY = 200,
    parameter int REPEAT_RATE  = 50
) (
    input  logic                     clk,
    input  logic                     rst_n,
    output logic [3:0]               col_out,
    input  logic [3:0]               row_in,
    keypad_scanner_if.master         kp
);
    localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    typedef enum logic [1:0] {IDLE, DEB_PRESS, PRESSED, DEB_REL} state_t;
    logic [3:0]    row_s1_q, row_s2_q;
    logic [DW-1:0] div_q, div_d;
    logic [1:0]    col_q, col_d;
    logic [15:0]   map_q, map_d, col_hits, scan_map;
    state_t        state_q, state_d;
    logic [7:0]    cnt_q, cnt_d, cnt_inc;
    logic [3:0]    cand_q, cand_d, key;
    logic [4:0]    code_q, code_d;
    logic          strobe_q, strobe_d, held_q, held_d;
    logic          tick, scan_done, single, hit_cand;
`ifdef KEYPAD_AUTOREPEAT_EN
    logic [15:0]   rep_q, rep_d, rep_inc;
    logic          first_q, first_d;
`else
    logic          unused_rep;
    assign unused_rep = ^{REPEAT_DELAY[0], REPEAT_RATE[0]};
`endif
    assign col_out        = ~(4'b0001 << col_q);
    assign kp.key_code    = code_q;
    assign kp.key_pressed = strobe_q;
    assign kp.key_held    = held_q;
    // Place the pressed rows of the current column at bit row*4+col of the scan map
    assign col_hits  = {3'b0, ~row_s2_q[3], 3'b0, ~row_s2_q[2], 3'b0, ~row_s2_q[1], 3'b0, ~row_s2_q[0]} << col_q;
    assign scan_map  = map_q | col_hits;
    assign tick      = div_q == DW'(SCAN_DIV - 1);
    assign scan_done = tick && col_q == 2'd3;
    assign single    = scan_map != 16'd0 && (scan_map & (scan_map - 16'd1)) == 16'd0;
    // One-hot to index; only meaningful when single is set
    assign key       = {|(scan_map & 16'hFF00), |(scan_map & 16'hF0F0), |(scan_map & 16'hCCCC), |(scan_map & 16'hAAAA)};
    assign hit_cand  = single && key == cand_q;
    assign cnt_inc   = cnt_q == 8'hFF ? cnt_q : cnt_q + 8'd1;
`ifdef KEYPAD_AUTOREPEAT_EN
    assign rep_inc   = rep_q == 16'hFFFF ? rep_q : rep_q + 16'd1;
`endif
    always_comb begin
        div_d    = tick ? '0 : div_q + DW'(1);
        col_d    = tick ? col_q + 2'd1 : col_q;
        map_d    = tick ? (col_q == 2'd3 ? 16'd0 : scan_map) : map_q;
        state_d  = state_q;
        cnt_d    = cnt_q;
        cand_d   = cand_q;
        code_d   = code_q;
        strobe_d = 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
        rep_d    = rep_q;
        first_d  = first_q;
`endif
        if (scan_done) begin
            case (state_q)
                IDLE: if (single) begin
                    cand_d = key;
                    cnt_d  = 8'd1;
                    if (DEBOUNCE_CNT == 1) begin
                        state_d  = PRESSED;
                        strobe_d = 1'b1;
                        code_d   = {1'b0, key};
                    end else state_d = DEB_PRESS;
                end
                DEB_PRESS: if (hit_cand) begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == 8'(DEBOUNCE_CNT)) begin
                        state_d  = PRESSED;
                        strobe_d = 1'b1;
                        code_d   = {1'b0, cand_q};
                    end
                end else state_d = IDLE;
                PRESSED: begin
                    if (!hit_cand) begin
                        cnt_d   = 8'd1;
                        state_d = DEBOUNCE_CNT == 1 ? IDLE : DEB_REL;
                    end
`ifdef KEYPAD_AUTOREPEAT_EN
                    // First repeat after REPEAT_DELAY scans, then every REPEAT_RATE scans
                    else if (rep_inc == (first_q ? 16'(REPEAT_RATE) : 16'(REPEAT_DELAY))) begin
                        rep_d    = 16'd0;
                        first_d  = 1'b1;
                        strobe_d = 1'b1;
                        code_d   = {1'b1, cand_q};
                    end else rep_d = rep_inc;
`endif
                end
                DEB_REL: if (hit_cand) state_d = PRESSED;
                else begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == 8'(DEBOUNCE_CNT)) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
`ifdef KEYPAD_AUTOREPEAT_EN
        if (state_d == IDLE) begin
            rep_d   = 16'd0;
            first_d = 1'b0;
        end
`endif
        held_d = state_d == PRESSED || state_d == DEB_REL;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_s1_q <= 4'hF;
            row_s2_q <= 4'hF;
            div_q    <= '0;
            col_q    <= 2'd0;
            map_q    <= 16'd0;
            state_q  <= IDLE;
            cnt_q    <= 8'd0;
            cand_q   <= 4'd0;
            code_q   <= 5'd0;
            strobe_q <= 1'b0;
            held_q   <= 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
            rep_q    <= 16'd0;
            first_q  <= 1'b0;
`endif
        end else begin
            row_s1_q <= row_in;
            row_s2_q <= row_s1_q;
            div_q    <= div_d;
            col_q    <= col_d;
            map_q    <= map_d;
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            cand_q   <= cand_d;
            code_q   <= code_d;
            strobe_q <= strobe_d;
            held_q   <= held_d;
`ifdef KEYPAD_AUTOREPEAT_EN
            rep_q    <= rep_d;
            first_q  <= first_d;
`endif
        end
    end
endmodule
